// File: rtl/vector_mux_pkg.sv
// vector_mux_pkg -- shared constants and types for the vector_mux block.
//
// Contents:
//   WIDTH   default bit width of one vector lane (one IEEE-754 single word)
//   LANES   number of lanes per vector (fixed at 4)
//   lane_t  one lane word, logic [WIDTH-1:0]
//   vec_zero_lane()  all-zero lane word, the value outputs take in reset
package vector_mux_pkg;

  localparam int WIDTH = 32;
  localparam int LANES = 4;

  typedef logic [WIDTH-1:0] lane_t;

  function automatic lane_t vec_zero_lane();
    return '0;
  endfunction

endpackage

// File: rtl/vector_mux_if.sv
// vector_mux_if -- bundle of the two input vectors, the select and the
// selected output vector, one array entry per lane (index 0 = lane 1).
//
// Signals:
//   vin_a[LANES]  vector A lanes
//   vin_b[LANES]  vector B lanes
//   control       0 selects A, 1 selects B
//   vout[LANES]   selected vector
//
// Modports:
//   master  drives the vectors and select, observes vout (stimulus side)
//   slave   receives the vectors and select, drives vout (mux side)
interface vector_mux_if
  import vector_mux_pkg::*;
#(
  parameter int WIDTH = vector_mux_pkg::WIDTH
);

  logic [WIDTH-1:0] vin_a [LANES];
  logic [WIDTH-1:0] vin_b [LANES];
  logic             control;
  logic [WIDTH-1:0] vout  [LANES];

  modport master (
    output vin_a,
    output vin_b,
    output control,
    input  vout
  );

  modport slave (
    input  vin_a,
    input  vin_b,
    input  control,
    output vout
  );

endinterface

// File: rtl/vector_mux_lane_mux.sv
// lane_mux -- one 2:1 selection of a WIDTH-bit lane word.
//
// Ports:
//   i_a    lane word from vector A
//   i_b    lane word from vector B
//   i_sel  0 passes i_a, 1 passes i_b
//   o_y    selected word, bit-exact copy of the chosen input
module lane_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  // Plain bit selection: lane words are never interpreted as floats.
  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/vector_mux.sv
// vector_mux -- selects one of two 4-lane vectors with a single control bit.
//
// Ports:
//   clk            rising-edge clock (used only with the output register)
//   rst            synchronous active-high reset (output register only)
//   vin11..vin14   vector A, lanes 1..4
//   vin21..vin24   vector B, lanes 1..4
//   control        0 = vector A, 1 = vector B, shared by all lanes
//   vout1..vout4   selected vector, lanes 1..4
//
// Build option:
//   VECTOR_MUX_OUTREG_EN  defined   -> outputs registered, 1-cycle latency,
//                                      cleared to zero by rst
//                         undefined -> outputs purely combinational,
//                                      clk and rst have no effect
// The port list is the same in both builds.
module vector_mux
  import vector_mux_pkg::*;
#(
  parameter int WIDTH = vector_mux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vin11,
  input  logic [WIDTH-1:0] vin12,
  input  logic [WIDTH-1:0] vin13,
  input  logic [WIDTH-1:0] vin14,
  input  logic [WIDTH-1:0] vin21,
  input  logic [WIDTH-1:0] vin22,
  input  logic [WIDTH-1:0] vin23,
  input  logic [WIDTH-1:0] vin24,
  input  logic             control,
  output logic [WIDTH-1:0] vout1,
  output logic [WIDTH-1:0] vout2,
  output logic [WIDTH-1:0] vout3,
  output logic [WIDTH-1:0] vout4
);

  logic [WIDTH-1:0] w_a   [LANES];
  logic [WIDTH-1:0] w_b   [LANES];
  logic [WIDTH-1:0] w_sel [LANES];
  logic [WIDTH-1:0] w_out [LANES];

  assign w_a[0] = vin11;
  assign w_a[1] = vin12;
  assign w_a[2] = vin13;
  assign w_a[3] = vin14;

  assign w_b[0] = vin21;
  assign w_b[1] = vin22;
  assign w_b[2] = vin23;
  assign w_b[3] = vin24;

  // Every lane sees the same control net, so lanes can never be mixed
  // between the two vectors within one cycle.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      lane_mux #(
        .WIDTH (WIDTH)
      ) u_lane_mux (
        .i_a   (w_a[gi]),
        .i_b   (w_b[gi]),
        .i_sel (control),
        .o_y   (w_sel[gi])
      );
    end
  endgenerate

`ifdef VECTOR_MUX_OUTREG_EN
  logic [WIDTH-1:0] r_vout [LANES];

  // No enable: each lane recaptures its selected word on every edge,
  // and reset wins over capture.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_outreg
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vout[gi] <= '0;
        end else begin
          r_vout[gi] <= w_sel[gi];
        end
      end

      assign w_out[gi] = r_vout[gi];
    end
  endgenerate
`else
  // Clock and reset are deliberately unused in the combinational build;
  // fold them into a sink so the port list stays identical.
  logic w_unused;
  assign w_unused = ^{clk, rst};

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_comb
      assign w_out[gi] = w_sel[gi];
    end
  endgenerate
`endif

  assign vout1 = w_out[0];
  assign vout2 = w_out[1];
  assign vout3 = w_out[2];
  assign vout4 = w_out[3];

endmodule

// File: tb/tb_vector_mux.sv
// tb_vector_mux -- directed, self-checking bench for vector_mux.
// Works for both builds: define VECTOR_MUX_OUTREG_EN on the command line
// for the registered build, leave it undefined for the combinational one.
// Each step drives both vectors, control and rst, pushes the expected
// output vector into a scoreboard queue, and pops it when the DUT output
// is due (same cycle combinationally, after the next edge when registered).
module tb_vector_mux;
  import vector_mux_pkg::*;

`ifdef VECTOR_MUX_OUTREG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vector_mux_if vif ();

  vector_mux #(
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .vin11   (vif.vin_a[0]),
    .vin12   (vif.vin_a[1]),
    .vin13   (vif.vin_a[2]),
    .vin14   (vif.vin_a[3]),
    .vin21   (vif.vin_b[0]),
    .vin22   (vif.vin_b[1]),
    .vin23   (vif.vin_b[2]),
    .vin24   (vif.vin_b[3]),
    .control (vif.control),
    .vout1   (vif.vout[0]),
    .vout2   (vif.vout[1]),
    .vout3   (vif.vout[2]),
    .vout4   (vif.vout[3])
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  vec_t out_now;
  bit   have_out = 1'b0;

  function automatic vec_t mk(lane_t w1, lane_t w2, lane_t w3, lane_t w4);
    vec_t v;
    v[0] = w1;
    v[1] = w2;
    v[2] = w3;
    v[3] = w4;
    return v;
  endfunction

  // Reference behaviour: registered build clears under reset, otherwise
  // the whole vector follows control.
  function automatic vec_t model(vec_t a, vec_t b, bit c, bit r);
    if (REG && r) return '0;
    return c ? b : a;
  endfunction

  task automatic check_vec(input string tag, input vec_t exp);
    for (int k = 0; k < LANES; k++) begin
      n_tests++;
      assert (vif.vout[k] === exp[k])
      else begin
        n_fail++;
        $error("FAIL %s lane%0d: observed %h expected %h", tag, k + 1, vif.vout[k], exp[k]);
      end
    end
  endtask

  // Called at edge+1; returns at the following edge+1.
  task automatic step(input string tag, input vec_t a, input vec_t b, input bit c, input bit r);
    vec_t e;
    for (int k = 0; k < LANES; k++) begin
      vif.vin_a[k] = a[k];
      vif.vin_b[k] = b[k];
    end
    vif.control = c;
    rst         = r;
    exp_q.push_back(model(a, b, c, r));
    #1;
    if (REG) begin
      // Output must not move before the edge.
      if (have_out) check_vec({tag, "/hold"}, out_now);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_vec(tag, e);
    end else begin
      e = exp_q.pop_front();
      check_vec(tag, e);
      @(posedge clk);
      #1;
      // A clock edge (with or without rst) must not disturb the output.
      check_vec({tag, "/post"}, e);
    end
    out_now  = e;
    have_out = 1'b1;
    $display("[TB] %-12s c=%0d r=%0d exp=%h %h %h %h", tag, c, r, e[0], e[1], e[2], e[3]);
  endtask

  vec_t va, vb, vz, wa, wb;

  initial begin
    va = mk(32'h41BA6666, 32'h3F99999A, 32'h40666666, 32'h40B9999A);
    vb = mk(32'h40DCCCCD, 32'h4259999A, 32'h42C7CCCD, 32'h416CCCCD);
    vz = '0;

    rst         = 1'b1;
    vif.control = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      vif.vin_a[k] = '0;
      vif.vin_b[k] = '0;
    end
    @(posedge clk);
    #1;

    // Reset held two cycles with B selected and data applied.
    step("reset1", va, vb, 1'b1, 1'b1);
    step("reset2", va, vb, 1'b1, 1'b1);
    step("rst_rel", va, vb, 1'b1, 1'b0);

    // Basic selection and switching.
    step("selA", va, vb, 1'b0, 1'b0);
    step("selA2", va, vb, 1'b0, 1'b0);
    step("selB", va, vb, 1'b1, 1'b0);

    // Control toggles every cycle with fixed data.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("toggle%0d", i), va, vb, i[0], 1'b0);
    end

    // Control and data change together.
    step("swap_data", vb, va, 1'b0, 1'b0);
    step("swap_ctrl", va, vb, 1'b0, 1'b0);

    // Reset in the middle of traffic, then recovery.
    step("mid_rst", va, vb, 1'b0, 1'b1);
    step("mid_rst_B", va, vb, 1'b1, 1'b1);
    step("post_rst", va, vb, 1'b0, 1'b0);

    // Walking one on every lane of each vector, under both selects.
    for (int k = 0; k < LANES; k++) begin
      for (int bt = 0; bt < WIDTH; bt++) begin
        wa = '0;
        wa[k][bt] = 1'b1;
        step($sformatf("wA_l%0d_b%0d_c0", k + 1, bt), wa, vz, 1'b0, 1'b0);
        step($sformatf("wA_l%0d_b%0d_c1", k + 1, bt), wa, vz, 1'b1, 1'b0);
        wb = '0;
        wb[k][bt] = 1'b1;
        step($sformatf("wB_l%0d_b%0d_c0", k + 1, bt), vz, wb, 1'b0, 1'b0);
        step($sformatf("wB_l%0d_b%0d_c1", k + 1, bt), vz, wb, 1'b1, 1'b0);
      end
    end

    // Selection while rst is held (tracks inputs only in the combinational build).
    step("rst_hold_A", va, vb, 1'b0, 1'b1);
    step("rst_hold_B", va, vb, 1'b1, 1'b1);
    step("rst_hold_A2", vb, va, 1'b0, 1'b1);
    step("final", va, vb, 1'b1, 1'b0);

    n_tests++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
